// File: rtl/gate_array_regs.sv
// gate_array_regs
//   Register file of the CPC Gate Array. Decodes CPU I/O writes aimed at the
//   Gate Array port and holds the pen-select register, the 16-entry ink table,
//   the border ink and the mode/ROM-control register. It translates the video
//   block's pen into an ink index and raises a one-cycle interrupt-counter
//   clear on request.
//
//   Optional feature macro: GA_MODE_SYNC_EN
//     defined   - a mode write only updates pending_mode; mode follows it at
//                 the start of each horizontal sync (no mid-line change)
//     undefined - mode follows the mode write directly; hsync_n is unused
//
//   Ports
//     clk, reset            system clock, asynchronous active-high reset
//     io_wr                 CPU I/O write strobe (level)
//     io_addr[15:0]         CPU I/O address, port selected when [15:14]=01
//     io_data[7:0]          CPU write data, command in [7:6]
//     hsync_n               video horizontal sync, active-low
//     pen[3:0]              pen being displayed
//     color[4:0]            ink index of pen (combinational)
//     border_color[4:0]     border ink index
//     mode[1:0]             active screen mode
//     int_clear             one-cycle interrupt-counter reset pulse
//     lower_rom_en          lower ROM paged in
//     upper_rom_en          upper ROM paged in
//
//   Write handshake: the strobe is level-sensitive and may be held for any
//   number of cycles. A write is taken only on the edge where io_wr is high,
//   was low on the previous edge and the port is selected, so each strobe
//   assertion commits exactly one write; the result is visible on the
//   outputs one cycle after that edge.

module gate_array_regs #(
  parameter logic [4:0] RESET_INK  = 5'd20,
  parameter logic [1:0] RESET_MODE = 2'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [7:0]  io_data,
  input  logic        hsync_n,
  input  logic [3:0]  pen,
  output logic [4:0]  color,
  output logic [4:0]  border_color,
  output logic [1:0]  mode,
  output logic        int_clear,
  output logic        lower_rom_en,
  output logic        upper_rom_en
);

  localparam logic [1:0] CMD_PENSEL = 2'b00;
  localparam logic [1:0] CMD_INK    = 2'b01;
  localparam logic [1:0] CMD_MRER   = 2'b10;

  logic       io_wr_q;
  // Low for the first edge after reset release. A strobe still held high
  // across reset must not look like a fresh rising edge, and an hsync that is
  // already low must not look like a fresh sync start.
  logic       armed;
  logic       sel_border;
  logic [3:0] sel_pen;
  logic [4:0] ink [16];
  logic [1:0] pending_mode;

  logic       select;
  logic       wr_edge;
  logic [1:0] cmd;
  logic       mrer_wr;

  assign select  = (io_addr[15:14] == 2'b01);
  assign wr_edge = armed && io_wr && !io_wr_q && select;
  assign cmd     = io_data[7:6];
  assign mrer_wr = wr_edge && (cmd == CMD_MRER);

  // No pipeline toward the video block: an ink change shows up mid-character.
  assign color = ink[pen];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_wr_q      <= 1'b0;
      armed        <= 1'b0;
      sel_border   <= 1'b0;
      sel_pen      <= 4'd0;
      for (int i = 0; i < 16; i++) ink[i] <= RESET_INK;
      border_color <= RESET_INK;
      pending_mode <= RESET_MODE;
      lower_rom_en <= 1'b1;
      upper_rom_en <= 1'b1;
      int_clear    <= 1'b0;
    end else begin
      io_wr_q   <= io_wr;
      armed     <= 1'b1;
      // Only the write edge can raise it, so it drops after one cycle even
      // when the strobe is held.
      int_clear <= mrer_wr && io_data[4];
      if (wr_edge) begin
        case (cmd)
          CMD_PENSEL: begin
            sel_border <= io_data[4];
            sel_pen    <= io_data[3:0];
          end
          CMD_INK: begin
            // Inks 27-31 are kept as written.
            if (sel_border) border_color     <= io_data[4:0];
            else            ink[sel_pen]     <= io_data[4:0];
          end
          CMD_MRER: begin
            pending_mode <= io_data[1:0];
            lower_rom_en <= !io_data[2];
            upper_rom_en <= !io_data[3];
          end
          default: ; // command 11 is not decoded by this block
        endcase
      end
    end
  end

`ifdef GA_MODE_SYNC_EN
  logic hsync_q;
  logic hsync_start;

  assign hsync_start = armed && hsync_q && !hsync_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_q <= 1'b1;
      mode    <= RESET_MODE;
    end else begin
      hsync_q <= hsync_n;
      // A mode write landing on the sync-start edge is forwarded so it is
      // not lost until the next line.
      if (hsync_start) mode <= mrer_wr ? io_data[1:0] : pending_mode;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{io_addr[13:0], io_data[5]};
`else
  assign mode = pending_mode;

  logic unused_bits;
  assign unused_bits = ^{io_addr[13:0], io_data[5], hsync_n};
`endif

endmodule
